async_fifo_sync_ptr_multi: RTL and testbench

//  Parametrised multi-channel Gray pointer synchroniser for the async FIFO family.

---
 rtl/async_fifo_pkg.sv | 29 ++
 rtl/async_fifo_sync_chan.sv | 83 ++++++++
 rtl/async_fifo_sync_ptr_multi.sv | 76 +++++++
 tb/tb_async_fifo_sync_ptr_multi.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Package: async_fifo_pkg
// Shared definitions for the async FIFO family: Gray/binary conversion helpers,
// pointer width derivation and the minimum synchroniser depth.
// Functions operate on 32-bit values; callers zero-extend narrower pointers
// and truncate the result back to their own width.
package async_fifo_pkg;

   // Fewer than two flops per bit gives no meaningful MTBF improvement.
   localparam int SYNC_MIN = 2;

   // Pointer width: one extra bit beyond the address so full/empty can be told apart.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/async_fifo_sync_chan.sv
// Module: async_fifo_sync_chan
// One pointer channel: SYNC_STAGES-deep synchroniser for a Gray pointer, then
// registered binary conversion, modular advance delta, advance flag and a
// sticky error for advances larger than MAX_STEP.
// Ports:
//   wclk      destination clock
//   wrst      synchronous reset, active-high
//   valid     warm-up complete (from the top); gates q_adv and error setting
//   err_clr   clears gray_err unless a new error is set at the same edge
//   ptr_in    Gray pointer from the source domain
//   q_gray    last synchroniser stage
//   q_bin     registered binary form of q_gray
//   q_delta   registered q_bin(new) - q_bin(old), modulo 2^PW
//   q_adv     registered: delta nonzero while valid
//   gray_err  sticky step error
module async_fifo_sync_chan
   import async_fifo_pkg::*;
#(
   parameter int PW          = 5,
   parameter int SYNC_STAGES = 2,
   parameter int MAX_STEP    = 16
) (
   input  logic          wclk,
   input  logic          wrst,
   input  logic          valid,
   input  logic          err_clr,
   input  logic [PW-1:0] ptr_in,
   output logic [PW-1:0] q_gray,
   output logic [PW-1:0] q_bin,
   output logic [PW-1:0] q_delta,
   output logic          q_adv,
   output logic          gray_err
);

   localparam logic [31:0] MAX_STEP_U = 32'(MAX_STEP);

   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic [PW-1:0] bin_now;
   logic [PW-1:0] delta_now;
   logic          step_err;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= ptr_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign q_gray = sync_q[SYNC_STAGES-1];

   // Modular subtraction makes the 2^PW-1 -> 0 wrap read as a single step.
   always_comb begin
      bin_now   = PW'(gray2bin(32'(q_gray)));
      delta_now = bin_now - q_bin;
      step_err  = valid && (32'(delta_now) > MAX_STEP_U);
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         q_bin    <= '0;
         q_delta  <= '0;
         q_adv    <= 1'b0;
         gray_err <= 1'b0;
      end else begin
         q_bin   <= bin_now;
         q_delta <= delta_now;
         q_adv   <= valid && (delta_now != '0);
         // A new error outranks a clear at the same edge so no event is lost.
         if (step_err) begin
            gray_err <= 1'b1;
         end else if (err_clr) begin
            gray_err <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/async_fifo_sync_ptr_multi.sv
// Module: async_fifo_sync_ptr_multi
// Multi-channel Gray pointer synchroniser into the wclk domain. Each channel
// is an async_fifo_sync_chan; a shared warm-up counter holds q_valid low until
// the synchroniser pipeline has been refilled after reset.
// Ports:
//   wclk      destination clock
//   wrst      synchronous reset, active-high
//   ptr_in    NCH Gray pointers, channel c at [c*PW +: PW]
//   err_clr   clears all gray_err bits
//   q_gray    synchronised Gray pointers
//   q_bin     registered binary pointers
//   q_delta   registered per-sample advance, modulo 2^PW
//   q_adv     per channel: advance seen this cycle
//   q_valid   pipeline filled since the last reset
//   gray_err  per channel sticky step error
module async_fifo_sync_ptr_multi
   import async_fifo_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int NCH         = 1,
   parameter int SYNC_STAGES = 2,
   parameter int MAX_STEP    = DEPTH
) (
   input  logic                           wclk,
   input  logic                           wrst,
   input  logic [NCH*ptr_w(DEPTH)-1:0]    ptr_in,
   input  logic                           err_clr,
   output logic [NCH*ptr_w(DEPTH)-1:0]    q_gray,
   output logic [NCH*ptr_w(DEPTH)-1:0]    q_bin,
   output logic [NCH*ptr_w(DEPTH)-1:0]    q_delta,
   output logic [NCH-1:0]                 q_adv,
   output logic                           q_valid,
   output logic [NCH-1:0]                 gray_err
);

   localparam int PW       = ptr_w(DEPTH);
   localparam int WARM_MAX = SYNC_STAGES + 1;
   localparam int CW       = $clog2(WARM_MAX + 1);

   if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
      $error("async_fifo_sync_ptr_multi: SYNC_STAGES must be >= SYNC_MIN");
   end

   logic [CW-1:0] warm_cnt;

   // Counts edges since reset release and saturates; q_valid follows saturation.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         warm_cnt <= '0;
      end else if (warm_cnt != CW'(WARM_MAX)) begin
         warm_cnt <= warm_cnt + 1'b1;
      end
   end

   assign q_valid = (warm_cnt == CW'(WARM_MAX));

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      async_fifo_sync_chan #(
         .PW          (PW),
         .SYNC_STAGES (SYNC_STAGES),
         .MAX_STEP    (MAX_STEP)
      ) u_chan (
         .wclk     (wclk),
         .wrst     (wrst),
         .valid    (q_valid),
         .err_clr  (err_clr),
         .ptr_in   (ptr_in[c*PW +: PW]),
         .q_gray   (q_gray[c*PW +: PW]),
         .q_bin    (q_bin[c*PW +: PW]),
         .q_delta  (q_delta[c*PW +: PW]),
         .q_adv    (q_adv[c]),
         .gray_err (gray_err[c])
      );
   end

endmodule

// File: tb/tb_async_fifo_sync_ptr_multi.sv
// Bench for async_fifo_sync_ptr_multi with DEPTH=16 (PW=5), NCH=3,
// SYNC_STAGES=3, MAX_STEP=16.
// Scoreboard entries: {adv[2:0], bin ch2..ch0, delta ch2..ch0}; the monitor
// pops one entry whenever q_adv is nonzero.
module tb_async_fifo_sync_ptr_multi;

   localparam int NCH  = 3;
   localparam int PW   = 5;
   localparam int SYNC = 3;

   logic        wclk = 1'b0;
   logic        wrst;
   logic        err_clr;
   logic [14:0] ptr_in;
   logic [14:0] q_gray;
   logic [14:0] q_bin;
   logic [14:0] q_delta;
   logic [2:0]  q_adv;
   logic        q_valid;
   logic [2:0]  gray_err;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   async_fifo_sync_ptr_multi #(
      .DEPTH       (16),
      .NCH         (NCH),
      .SYNC_STAGES (SYNC),
      .MAX_STEP    (16)
   ) dut (
      .wclk     (wclk),
      .wrst     (wrst),
      .ptr_in   (ptr_in),
      .err_clr  (err_clr),
      .q_gray   (q_gray),
      .q_bin    (q_bin),
      .q_delta  (q_delta),
      .q_adv    (q_adv),
      .q_valid  (q_valid),
      .gray_err (gray_err)
   );

   // Clock / reset block
   always #5 wclk = ~wclk;

   function automatic logic [4:0] tb_gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_q_gray"},   32'(q_gray),   32'd0);
      check({tag, "_q_bin"},    32'(q_bin),    32'd0);
      check({tag, "_q_delta"},  32'(q_delta),  32'd0);
      check({tag, "_q_adv"},    32'(q_adv),    32'd0);
      check({tag, "_q_valid"},  32'(q_valid),  32'd0);
      check({tag, "_gray_err"}, 32'(gray_err), 32'd0);
   endtask

   // Driver: apply binary pointers (Gray-coded on the wire) just after an edge.
   // ad/d* are the hand-computed advance mask and deltas for this vector.
   task automatic drive_vec(input logic [4:0] b0, input logic [4:0] b1, input logic [4:0] b2,
                            input logic [2:0] ad,
                            input logic [4:0] d0, input logic [4:0] d1, input logic [4:0] d2);
      @(posedge wclk);
      #1;
      ptr_in = {tb_gray(b2), tb_gray(b1), tb_gray(b0)};
      if (ad != 3'b000) begin
         exp_q.push_back({ad, b2, b1, b0, d2, d1, d0});
      end
   endtask

   // Advance n active edges, then land on the following falling edge.
   task automatic edges(input int n);
      repeat (n) @(posedge wclk);
      @(negedge wclk);
   endtask

   initial begin
      logic [32:0] item;
      wrst    = 1'b1;
      err_clr = 1'b0;
      ptr_in  = '0;

      // Monitor: compare every reported advance against the scoreboard.
      fork
         forever begin
            @(negedge wclk);
            if (q_adv != 3'b000) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_adv", 32'(q_adv), 32'd0);
               end else begin
                  item = exp_q.pop_front();
                  check("mon_adv",   32'(q_adv),   32'(item[32:30]));
                  check("mon_bin",   32'(q_bin),   32'(item[29:15]));
                  check("mon_delta", 32'(q_delta), 32'(item[14:0]));
               end
            end
         end
      join_none

      // Reset and warm-up
      repeat (3) @(posedge wclk);
      @(negedge wclk);
      check_all_zero("reset");
      @(posedge wclk);
      #1;
      wrst = 1'b0;
      for (int i = 1; i <= SYNC + 1; i++) begin
         edges(1);
         check($sformatf("warmup_valid_e%0d", i), 32'(q_valid), (i == SYNC + 1) ? 32'd1 : 32'd0);
      end
      check("warmup_q_bin", 32'(q_bin), 32'd0);

      // Latency: ch0 -> 5 (Gray 7)
      drive_vec(5'd5, 5'd0, 5'd0, 3'b001, 5'd5, 5'd0, 5'd0);
      edges(2);
      check("lat_gray_e2", 32'(q_gray[4:0]), 32'd0);
      edges(1);
      check("lat_gray_e3", 32'(q_gray[4:0]), 32'd7);
      check("lat_bin_e3",  32'(q_bin[4:0]),  32'd0);
      edges(1);
      check("lat_bin_e4",  32'(q_bin[4:0]),  32'd5);

      // Multi-channel: only ch1 advances by 2
      drive_vec(5'd5, 5'd2, 5'd0, 3'b010, 5'd0, 5'd2, 5'd0);
      edges(SYNC + 2);

      // Climb ch1 toward the wrap; ch2 steps exactly MAX_STEP (no error)
      drive_vec(5'd5, 5'd17, 5'd16, 3'b110, 5'd0, 5'd15, 5'd16);
      drive_vec(5'd5, 5'd29, 5'd16, 3'b010, 5'd0, 5'd12, 5'd0);
      // Wrap 30,31,0,1 one per cycle
      drive_vec(5'd5, 5'd30, 5'd16, 3'b010, 5'd0, 5'd1, 5'd0);
      drive_vec(5'd5, 5'd31, 5'd16, 3'b010, 5'd0, 5'd1, 5'd0);
      drive_vec(5'd5, 5'd0,  5'd16, 3'b010, 5'd0, 5'd1, 5'd0);
      drive_vec(5'd5, 5'd1,  5'd16, 3'b010, 5'd0, 5'd1, 5'd0);
      edges(SYNC + 2);
      check("wrap_no_err", 32'(gray_err), 32'd0);
      check("wrap_bin", 32'(q_bin), {17'd0, 5'd16, 5'd1, 5'd5});

      // Bring ch0 to 0 with steps of 11 and 16 (both legal)
      drive_vec(5'd16, 5'd1, 5'd16, 3'b001, 5'd11, 5'd0, 5'd0);
      drive_vec(5'd0,  5'd1, 5'd16, 3'b001, 5'd16, 5'd0, 5'd0);
      edges(SYNC + 2);
      check("step16_no_err", 32'(gray_err), 32'd0);

      // Jump 0 -> 20 on ch0: error, sticky
      drive_vec(5'd20, 5'd1, 5'd16, 3'b001, 5'd20, 5'd0, 5'd0);
      edges(SYNC + 1);
      check("jump_err_set", 32'(gray_err), 32'd1);
      edges(3);
      check("jump_err_sticky", 32'(gray_err), 32'd1);
      @(posedge wclk);
      #1;
      err_clr = 1'b1;
      @(posedge wclk);
      #1;
      err_clr = 1'b0;
      @(negedge wclk);
      check("err_cleared", 32'(gray_err), 32'd0);

      // Jump 20 -> 8 (delta 20) with err_clr at the very edge it is detected
      drive_vec(5'd8, 5'd1, 5'd16, 3'b001, 5'd20, 5'd0, 5'd0);
      repeat (SYNC) @(posedge wclk);
      #1;
      err_clr = 1'b1;
      @(posedge wclk);
      #1;
      err_clr = 1'b0;
      @(negedge wclk);
      check("set_beats_clr", 32'(gray_err), 32'd1);

      // Reset mid-run with ch0 at 9
      drive_vec(5'd9, 5'd1, 5'd16, 3'b001, 5'd1, 5'd0, 5'd0);
      edges(SYNC + 2);
      check("pre_rst_bin0", 32'(q_bin[4:0]), 32'd9);
      check("pre_rst_valid", 32'(q_valid), 32'd1);
      @(posedge wclk);
      #1;
      wrst = 1'b1;
      @(posedge wclk);
      #1;
      wrst = 1'b0;
      @(negedge wclk);
      check_all_zero("midrst");
      for (int i = 1; i <= SYNC + 1; i++) begin
         edges(1);
         check($sformatf("rewarm_valid_e%0d", i), 32'(q_valid), (i == SYNC + 1) ? 32'd1 : 32'd0);
      end
      check("rewarm_bin", 32'(q_bin), {17'd0, 5'd16, 5'd1, 5'd9});
      check("rewarm_err", 32'(gray_err), 32'd0);

      // Advances resume after the second warm-up
      drive_vec(5'd10, 5'd1, 5'd16, 3'b001, 5'd1, 5'd0, 5'd0);
      edges(SYNC + 3);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
